// File: rtl/gate_truth_table_checker_if.sv
// Stimulus/response bundle between the truth-table checker and its environment.
// With TT_STABILITY_CHECK_EN defined the bundle also carries the unstable flags.
interface gate_truth_table_checker_if;
    logic       start;
    logic [3:0] expected;
    logic       drv_a;
    logic       drv_b;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] tt;
    logic [3:0] err_mask;
`ifdef TT_STABILITY_CHECK_EN
    logic [3:0] unstable;

    modport master (
        input  start, expected, dut_y,
        output drv_a, drv_b, busy, done, pass, tt, err_mask, unstable
    );
    modport slave (
        output start, expected, dut_y,
        input  drv_a, drv_b, busy, done, pass, tt, err_mask, unstable
    );
`else
    modport master (
        input  start, expected, dut_y,
        output drv_a, drv_b, busy, done, pass, tt, err_mask
    );
    modport slave (
        output start, expected, dut_y,
        input  drv_a, drv_b, busy, done, pass, tt, err_mask
    );
`endif
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps a 2-input gate through 00,01,10,11, captures y after a settle window and
// compares against a latched expected table. Optional: TT_STABILITY_CHECK_EN.
module gate_truth_table_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    gate_truth_table_checker_if.master  tif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Per-entry mismatch between captured and expected tables.
    function automatic logic [3:0] tt_diff(input logic [3:0] got, input logic [3:0] want);
        return got ^ want;
    endfunction

    state_t           state_r, state_s;
    logic [1:0]       idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       drv_r, drv_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic [3:0]       tt_r, tt_s;
    logic [3:0]       err_r, err_s;
    logic [3:0]       exp_r, exp_s;
`ifdef TT_STABILITY_CHECK_EN
    logic             prev_y_r, prev_y_s;
    logic [3:0]       unstable_r, unstable_s;
`endif

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        drv_s   = drv_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        pass_s  = pass_r;
        tt_s    = tt_r;
        err_s   = err_r;
        exp_s   = exp_r;
`ifdef TT_STABILITY_CHECK_EN
        prev_y_s   = prev_y_r;
        unstable_s = unstable_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (tif.start) begin
                    exp_s   = tif.expected;
                    idx_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                    drv_s   = 2'b00;
                    busy_s  = 1'b1;
                    pass_s  = 1'b0;
                    state_s = ST_RUN;
`ifdef TT_STABILITY_CHECK_EN
                    unstable_s = 4'b0000;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef TT_STABILITY_CHECK_EN
                // The first cycle of each window is allowed to see the new vector settle.
                prev_y_s = tif.dut_y;
                if ((cnt_r != CNT_ZERO) && (tif.dut_y != prev_y_r)) begin
                    unstable_s[idx_r] = 1'b1;
                end else begin
                    unstable_s = unstable_r;
                end
`endif
                if (cnt_r == CNT_LAST) begin
                    tt_s[idx_r] = tif.dut_y;
                    cnt_s       = CNT_ZERO;
                    if (idx_r == 2'd3) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        err_s   = tt_diff(tt_s, exp_r);
`ifdef TT_STABILITY_CHECK_EN
                        pass_s  = (err_s == 4'b0000) && (unstable_s == 4'b0000);
`else
                        pass_s  = (err_s == 4'b0000);
`endif
                    end else begin
                        idx_s = idx_r + 2'd1;
                        drv_s = idx_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            cnt_r   <= CNT_ZERO;
            drv_r   <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            tt_r    <= 4'b0000;
            err_r   <= 4'b0000;
            exp_r   <= 4'b0000;
`ifdef TT_STABILITY_CHECK_EN
            prev_y_r   <= 1'b0;
            unstable_r <= 4'b0000;
`endif
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            drv_r   <= drv_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            tt_r    <= tt_s;
            err_r   <= err_s;
            exp_r   <= exp_s;
`ifdef TT_STABILITY_CHECK_EN
            prev_y_r   <= prev_y_s;
            unstable_r <= unstable_s;
`endif
        end
    end

    assign tif.drv_a    = drv_r[1];
    assign tif.drv_b    = drv_r[0];
    assign tif.busy     = busy_r;
    assign tif.done     = done_r;
    assign tif.pass     = pass_r;
    assign tif.tt       = tt_r;
    assign tif.err_mask = err_r;
`ifdef TT_STABILITY_CHECK_EN
    assign tif.unstable = unstable_r;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Self-checking bench: table-driven and random sweeps against a truth-table model,
// plus hand-written reset, start-hold and settle-window sequences.
module tb_gate_truth_table_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] tbl_a = 4'b0111;
    logic [3:0] tbl_b = 4'b0111;
    logic       glitch_b = 1'b0;

    gate_truth_table_checker_if ifa ();
    gate_truth_table_checker_if ifb ();

    assign ifa.dut_y = tbl_a[{ifa.drv_a, ifa.drv_b}];
    assign ifb.dut_y = tbl_b[{ifb.drv_a, ifb.drv_b}] ^ glitch_b;

    gate_truth_table_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .tif(ifa));
    gate_truth_table_checker #(.SETTLE_CYCLES(3), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .tif(ifb));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] tbl;
        logic [3:0] ex;
        logic [3:0] tt;
        logic [3:0] err;
        logic       ps;
        bit         noise;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    // Runs one sweep on dut_a; returns edges from acceptance to done and trace errors.
    task automatic sweep_a(input logic [3:0] tbl, input logic [3:0] ex, input bit noise,
                           output int lat, output int trace_err);
        tbl_a = tbl;
        ifa.expected = ex;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        lat = 0;
        trace_err = 0;
        if ({ifa.drv_a, ifa.drv_b} != 2'b00 || ifa.busy !== 1'b1) trace_err++;
        for (int m = 1; m <= 50 && lat == 0; m++) begin
            if (noise && m == 1) ifa.expected = ~ex;
            if (noise && m == 3) ifa.start = 1'b1;
            if (noise && m == 4) ifa.start = 1'b0;
            tick();
            if (ifa.done === 1'b1) lat = m;
            else if (int'({ifa.drv_a, ifa.drv_b}) != m / 2 || ifa.busy !== 1'b1) trace_err++;
        end
    endtask

    // Post-sweep checks for dut_a: results at done, then the done pulse falls.
    task automatic finish_a(input string nm, input int lat, input int trace_err,
                            input logic [3:0] tt, input logic [3:0] err, input logic ps);
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_trace"}, trace_err, 0);
        chk({nm, "_tt"}, ifa.tt, tt);
        chk({nm, "_err_mask"}, ifa.err_mask, err);
        chk({nm, "_pass"}, ifa.pass, ps);
        tick();
        chk({nm, "_done_fall"}, {ifa.done, ifa.busy, ifa.drv_a, ifa.drv_b}, 4'b0011);
    endtask

    initial begin
        int lat, terr;
        int done_at[$];
        logic b9, b10;
        int n_busy, n_done, d_at;
        logic [3:0] rt, rx;

        vecs[0] = '{4'b0111, 4'b0111, 4'b0111, 4'b0000, 1'b1, 1'b0};
        vecs[1] = '{4'b1000, 4'b0111, 4'b1000, 4'b1111, 1'b0, 1'b0};
        vecs[2] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[3] = '{4'b0110, 4'b0111, 4'b0110, 4'b0001, 1'b0, 1'b0};
        vecs[4] = '{4'b1110, 4'b1110, 4'b1110, 4'b0000, 1'b1, 1'b1};
        vecs[5] = '{4'b1001, 4'b0111, 4'b1001, 4'b1110, 1'b0, 1'b1};

        ifa.start = 1'b0; ifa.expected = 4'b0000;
        ifb.start = 1'b0; ifb.expected = 4'b0000;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_a", {ifa.drv_a, ifa.drv_b, ifa.busy, ifa.done, ifa.pass, ifa.tt, ifa.err_mask},
            13'h0000);
        tick();
        chk("idle_no_start", ifa.busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            sweep_a(vecs[i].tbl, vecs[i].ex, vecs[i].noise, lat, terr);
            finish_a($sformatf("vec%0d", i), lat, terr, vecs[i].tt, vecs[i].err, vecs[i].ps);
        end

        // Random tables against a plain truth-table model.
        for (int i = 0; i < 16; i++) begin
            rt = 4'($urandom);
            rx = ($urandom_range(0, 1) == 0) ? rt : 4'($urandom);
            sweep_a(rt, rx, bit'($urandom_range(0, 1)), lat, terr);
            finish_a($sformatf("rnd%0d", i), lat, terr, rt, rt ^ rx, rt == rx);
        end

        // Reset three edges into a sweep discards everything.
        sweep_a(4'b0110, 4'b0110, 1'b0, lat, terr);
        finish_a("pre_rst", lat, terr, 4'b0110, 4'b0000, 1'b1);
        tbl_a = 4'b0111; ifa.expected = 4'b0111; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", {ifa.drv_a, ifa.drv_b, ifa.busy, ifa.done, ifa.pass, ifa.tt, ifa.err_mask},
            13'h0000);
        sweep_a(4'b0111, 4'b0111, 1'b0, lat, terr);
        finish_a("post_rst", lat, terr, 4'b0111, 4'b0000, 1'b1);

        // Reset and start together: reset wins.
        rst = 1'b1; ifa.start = 1'b1;
        tick();
        rst = 1'b0; ifa.start = 1'b0;
        tick();
        chk("rst_start_same", {ifa.busy, ifa.done}, 2'b00);

        // Start held high: one idle gap after each done.
        ifa.start = 1'b1;
        b9 = 1'bx; b10 = 1'bx;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (ifa.done === 1'b1) done_at.push_back(t);
            if (t == 9) b9 = ifa.busy;
            if (t == 10) b10 = ifa.busy;
        end
        ifa.start = 1'b0;
        tick();
        chk("hold_done_count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            chk("hold_done0", done_at[0], 8);
            chk("hold_done1", done_at[1], 18);
        end else begin
            chk("hold_done_list", done_at.size(), 2);
        end
        chk("hold_gap_busy", {b9, b10}, 2'b01);
        chk("hold_pass", ifa.pass, 1'b1);

        // SETTLE_CYCLES=3 drive trace.
        tbl_b = 4'b0111; ifb.expected = 4'b0111; ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        n_busy = 0; n_done = 0; d_at = -1; terr = 0;
        for (int m = 0; m < 16; m++) begin
            if (m > 0) tick();
            if (ifb.busy === 1'b1) n_busy++;
            if (ifb.done === 1'b1) begin n_done++; d_at = m; end
            if (int'({ifb.drv_a, ifb.drv_b}) != ((m < 12) ? m / 3 : 3)) terr++;
        end
        chk("s3_busy_cycles", n_busy, 12);
        chk("s3_done_cycles", n_done, 1);
        chk("s3_done_at", d_at, 12);
        chk("s3_drv_trace", terr, 0);
        chk("s3_result", {ifb.pass, ifb.tt, ifb.err_mask}, 9'h170);

`ifdef TT_STABILITY_CHECK_EN
        // A glitch in the middle of vector 2's window is flagged.
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        d_at = -1;
        for (int m = 1; m < 16; m++) begin
            tick();
            if (m == 7) glitch_b = 1'b1;
            if (m == 8) glitch_b = 1'b0;
            if (ifb.done === 1'b1) d_at = m;
            if (m == 12) begin
                chk("stab_unstable", ifb.unstable, 4'b0100);
                chk("stab_tt", ifb.tt, 4'b0111);
                chk("stab_pass", ifb.pass, 1'b0);
            end
        end
        chk("stab_done_at", d_at, 12);
        chk("stab_clean_a", ifa.unstable, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
